udma_sdio_cmd_arb: RTL
======================

# udma_sdio_cmd_arb

Arbitrates and sequences SD commands from two independent requesters onto the single SDIO command/data engine. Requester 0 is typically the software register path and requester 1 a hardware autonomous agent (e.g. card-detect or polling logic). The block latches the winning command and pulses start to the engine. It supervises completion with end-of-transfer, error and timeout detection, then returns status to the granted requester only. It sits between the register interface / agents and the SDIO transmit-receive engine.

## Interface
- TIMEOUT_W, 24: width of the completion-timeout counter.
- TIMEOUT_CYCLES, 24'hFF_FFFF: cycles in WAIT before a timeout error is declared; must be ≥1.
- MAX_RETRY, 2: re-issue attempts after error (used only with SDIO_CMD_RETRY_EN).

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  2  per-requester command request, level, held until ack
- req_op_i  in  12  {op1, op0}, 6 bits each
- req_arg_i  in  64  {arg1, arg0}
- req_rsp_type_i  in  6  {type1, type0}
- req_data_en_i  in  2  per-requester data-phase enable
- ack_o  out  2  one-cycle pulse: command accepted
- done_o  out  2  one-cycle pulse: command finished
- err_o  out  1  valid with done_o: 1 = failed
- status_o  out  16  valid with done_o; held until next done
- busy_o  out  1  high whenever state ≠ IDLE
- cmd_op_o  out  6  to engine
- cmd_arg_o  out  32  to engine
- cmd_rsp_type_o  out  3  to engine
- data_en_o  out  1  to engine
- start_o  out  1  one-cycle start pulse to engine
- eot_i  in  1  engine end-of-transfer pulse
- err_i  in  1  engine error pulse
- status_i  in  16  engine status, sampled on eot_i/err_i

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_i is high, grant round-robin. The requester not granted last time wins a tie. After reset, requester 0 has priority. Latch op/arg/type/data_en of the winner into cmd_* registers, pulse ack_o[winner], go to ISSUE.
- ISSUE: start_o=1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT: the timeout counter increments every cycle.
  - err_i: capture status_i, go to RESP with err=1. Error takes precedence over a simultaneous eot_i.
  - eot_i alone: capture status_i, go to RESP with err=0.
  - Counter reaches TIMEOUT_CYCLES with no event: status=16'hFFFF, go to RESP with err=1.
- RESP: done_o[granted]=1, err_o valid, one cycle. Then go to IDLE and update the last-grant pointer.
- eot_i/err_i outside WAIT are ignored.
- Deasserting req_i after ack has no effect on the in-flight command.
- cmd_* outputs hold the last latched command until the next grant.

## Timing
- Reset values: all outputs 0; state IDLE; last-grant pointer = 1, so requester 0 wins first.
- req_i high in IDLE at cycle N:
  - ack_o at N, with cmd_* registered and visible at N+1.
  - start_o at N+1.
- eot_i at cycle M in WAIT gives done_o at M+1. Earliest next ack is M+2.
- Minimum command turnaround, with eot_i one cycle after start_o: 4 cycles from ack to ack.
- Timeout: done_o with err_o=1 occurs exactly TIMEOUT_CYCLES+1 cycles after start_o.
- Reset mid-command: immediately IDLE, no done_o issued, and the engine must be reset alongside.

## Configuration
- SDIO_CMD_RETRY_EN defined: an engine error (err_i, not timeout) with retry count < MAX_RETRY returns to ISSUE instead of RESP. That re-pulses start_o with the same latched command and increments the retry count. The retry count clears on grant. done_o is raised only on success, on the final error, or on timeout. status_o reports the last attempt.
- Not defined: no retry; every error goes straight to RESP. MAX_RETRY is unused.

## Test plan
- Single request: req_i=2'b01, op0=6'd17, arg0=32'h0000_0200. Required response: ack_o[0]; cmd_op_o=17, cmd_arg_o=h200; start_o one cycle later. Then eot_i with status_i=16'h0900 gives done_o[0], err_o=0, status_o=16'h0900.
- Contention: req_i=2'b11 held. Required response: grants alternate 0,1,0,1 over four commands, with done_o only on the granted bit each time.
- Simultaneous eot_i=1 and err_i=1 with status_i=16'h0004 → done_o, err_o=1, status_o=16'h0004.
- Timeout: TIMEOUT_CYCLES=16 and no engine event. Required response: done_o with err_o=1 and status_o=16'hFFFF exactly 17 cycles after start_o.
- With SDIO_CMD_RETRY_EN and MAX_RETRY=2: err_i on three consecutive attempts. Required response: three start_o pulses and a single done_o with err_o=1. Repeat with err_i then eot_i: two start_o pulses, then done_o with err_o=0.
- Assert rst_i in WAIT. Required response: all outputs 0 the same cycle and no done_o. After release, the next req_i=2'b11 grants requester 0.

Source files
------------

// File: rtl/udma_sdio_cmd_arb.sv
// udma_sdio_cmd_arb
// Two-requester round-robin arbiter and sequencer in front of the single SDIO
// command/data engine. It latches the winning command, pulses start_o to the
// engine, and watches for end-of-transfer, engine error or timeout. It then
// returns done/err/status to the granted requester only.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i[1:0]          per-requester level request, held until ack
//   req_op_i            {op1, op0}, 6 bits each
//   req_arg_i           {arg1, arg0}, 32 bits each
//   req_rsp_type_i      {type1, type0}, 3 bits each
//   req_data_en_i[1:0]  per-requester data-phase enable
//   ack_o[1:0]          same-cycle accept pulse while IDLE
//   done_o[1:0]         completion pulse to the granted requester
//   err_o, status_o     completion result, held until the next completion
//   busy_o              FSM not in IDLE
//   cmd_*_o, start_o    latched command and one-cycle start to the engine
//   eot_i, err_i        engine completion pulses (honoured only in WAIT)
//   status_i            engine status, sampled with eot_i/err_i
//
// Optional feature macro: SDIO_CMD_RETRY_EN. When it is defined, an engine
// error re-issues the same command up to MAX_RETRY times before it is
// reported. A timeout is never retried.
//
// The engine shares rst_i so that a reset in the middle of a command
// leaves both sides idle.

module udma_sdio_cmd_arb #(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(24'hFF_FFFF),
  parameter int                   MAX_RETRY      = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [11:0] req_op_i,
  input  logic [63:0] req_arg_i,
  input  logic [5:0]  req_rsp_type_i,
  input  logic [1:0]  req_data_en_i,
  output logic [1:0]  ack_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic [15:0] status_o,
  output logic        busy_o,
  output logic [5:0]  cmd_op_o,
  output logic [31:0] cmd_arg_o,
  output logic [2:0]  cmd_rsp_type_o,
  output logic        data_en_o,
  output logic        start_o,
  input  logic        eot_i,
  input  logic        err_i,
  input  logic [15:0] status_i
);

`ifdef SDIO_CMD_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);
  // The counter starts at 0 in the first WAIT cycle, so this value marks
  // the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic                 gnt;    // requester that owns the in-flight command
  logic                 last;   // last completed grant; round-robin pointer
  logic [TIMEOUT_W-1:0] tcnt;
  logic [RW-1:0]        retry_cnt;
  logic                 win;
  logic                 retry_ok;
  logic [1:0]           gnt_vec;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    win = (req_i == 2'b11) ? ~last : req_i[1];
  end

  // ack is combinational so that a requester sees acceptance in the cycle it
  // is granted. It is gated by reset so that every output reads 0 while
  // rst_i is high.
  always_comb begin
    ack_o = 2'b00;
    if (state == IDLE && !rst_i && (|req_i))
      ack_o = win ? 2'b10 : 2'b01;
  end

  assign busy_o   = (state != IDLE);
  assign retry_ok = RETRY_EN && (retry_cnt < MAX_R);
  assign gnt_vec  = gnt ? 2'b10 : 2'b01;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      gnt            <= 1'b0;
      last           <= 1'b1;
      tcnt           <= '0;
      retry_cnt      <= '0;
      cmd_op_o       <= '0;
      cmd_arg_o      <= '0;
      cmd_rsp_type_o <= '0;
      data_en_o      <= 1'b0;
      start_o        <= 1'b0;
      done_o         <= 2'b00;
      err_o          <= 1'b0;
      status_o       <= '0;
    end else begin
      start_o <= 1'b0;
      done_o  <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_i) begin
            gnt            <= win;
            cmd_op_o       <= win ? req_op_i[11:6]      : req_op_i[5:0];
            cmd_arg_o      <= win ? req_arg_i[63:32]    : req_arg_i[31:0];
            cmd_rsp_type_o <= win ? req_rsp_type_i[5:3] : req_rsp_type_i[2:0];
            data_en_o      <= req_data_en_i[win];
            retry_cnt      <= '0;
            start_o        <= 1'b1;   // high during the ISSUE cycle
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + TIMEOUT_W'(1);
          if (err_i) begin
            // An error wins over a simultaneous eot.
            if (retry_ok) begin
              retry_cnt <= retry_cnt + RW'(1);
              start_o   <= 1'b1;
              state     <= ISSUE;
            end else begin
              status_o <= status_i;
              err_o    <= 1'b1;
              done_o   <= gnt_vec;
              state    <= RESP;
            end
          end else if (eot_i) begin
            status_o <= status_i;
            err_o    <= 1'b0;
            done_o   <= gnt_vec;
            state    <= RESP;
          end else if (tcnt == TO_LAST) begin
            status_o <= 16'hFFFF;
            err_o    <= 1'b1;
            done_o   <= gnt_vec;
            state    <= RESP;
          end
        end
        RESP: begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
